// File: rtl/fetch_unit_if.sv
// Bus between the fetch unit and its controller: program-store loading,
// run control, and the issued instruction stream with run status.
interface fetch_unit_if;
  logic        prog_wr;
  logic [4:0]  prog_addr;
  logic [14:0] prog_data;
  logic        start;
  logic        halt_req;
  logic [14:0] pgm_mem;
  logic [4:0]  pc;
  logic        busy;
  logic        done;
  logic [5:0]  issue_cnt;

  modport master (
    output prog_wr, prog_addr, prog_data, start, halt_req,
    input  pgm_mem, pc, busy, done, issue_cnt
  );

  modport slave (
    input  prog_wr, prog_addr, prog_data, start, halt_req,
    output pgm_mem, pc, busy, done, issue_cnt
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: a small writable program store that is stepped
// through on each run, issuing one registered word per clock until a halt.
module fetch_unit #(
  parameter int       PGM_DEPTH = 32,
  parameter bit [3:0] HALT_OP   = 4'b1111
) (
  input  logic       clk_fu,
  input  logic       rst_fu,
  fetch_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  localparam logic [4:0] LAST_PC = 5'(PGM_DEPTH - 1);

  state_t      state_q, state_d;
  logic [4:0]  pc_q, pc_d;
  logic [14:0] word_q, word_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        busy_q, done_q;
  logic        wr_en;
  logic [14:0] cur_word;

  logic [14:0] mem [PGM_DEPTH];

  assign cur_word = mem[pc_q];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    word_d  = 15'h0000;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    unique case (state_q)
      IDLE, HALTED: begin
        // A write wins over start in the same cycle.
        if (bus.prog_wr) begin
          wr_en = 1'b1;
        end else if (bus.start) begin
          state_d = RUN;
          pc_d    = 5'd0;
          cnt_d   = 6'd0;
        end
      end
      RUN: begin
        if (bus.halt_req || (cur_word[14:11] == HALT_OP)) begin
          state_d = HALTED;
        end else begin
          word_d = cur_word;
          cnt_d  = (cnt_q == 6'd63) ? cnt_q : cnt_q + 6'd1;
          if (pc_q == LAST_PC) begin
            pc_d    = 5'd0;
            state_d = HALTED;
          end else begin
            pc_d = pc_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_fu) begin
    if (rst_fu) begin
      state_q <= IDLE;
      pc_q    <= 5'd0;
      word_q  <= 15'h0000;
      cnt_q   <= 6'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == HALTED);
    end
  end

  // Program contents survive reset; only the write itself is blocked.
  always_ff @(posedge clk_fu) begin
    if (!rst_fu && wr_en) begin
      mem[bus.prog_addr] <= bus.prog_data;
    end
  end

  assign bus.pgm_mem   = word_q;
  assign bus.pc        = pc_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.issue_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a queue-based program model predicts each
// run's issued words and final status; a monitor checks issues as they occur.
module tb_fetch_unit;

  logic clk_fu = 1'b0;
  logic rst_fu;

  fetch_unit_if bus ();

  fetch_unit #(.PGM_DEPTH(32), .HALT_OP(4'b1111)) dut (
    .clk_fu(clk_fu),
    .rst_fu(rst_fu),
    .bus   (bus)
  );

  always #5 clk_fu = ~clk_fu;

  logic [14:0] model_mem [32];
  logic [14:0] exp_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [5:0]  prev_cnt = 6'd0;
  bit          checking_on = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // An issue is any edge where issue_cnt steps up by exactly one.
  always @(negedge clk_fu) begin
    if (checking_on) begin
      if (bus.issue_cnt == prev_cnt + 6'd1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_issue: got word 0x%0h, expected no issue", bus.pgm_mem);
        end else begin
          checkOutput("issued_word", 32'(bus.pgm_mem), 32'(exp_q.pop_front()));
        end
      end
      checkOutput("busy_done_exclusive", 32'(bus.busy & bus.done), 32'd0);
    end
    prev_cnt = bus.issue_cnt;
  end

  task automatic applyStimulus(input logic wr, input logic [4:0] addr,
                               input logic [14:0] data, input logic st,
                               input logic hr);
    bus.prog_wr   = wr;
    bus.prog_addr = addr;
    bus.prog_data = data;
    bus.start     = st;
    bus.halt_req  = hr;
    @(posedge clk_fu);
    #1;
    bus.prog_wr   = 1'b0;
    bus.prog_addr = 5'd0;
    bus.prog_data = 15'd0;
    bus.start     = 1'b0;
    bus.halt_req  = 1'b0;
  endtask

  task automatic write_word(input logic [4:0] addr, input logic [14:0] data);
    applyStimulus(1'b1, addr, data, 1'b0, 1'b0);
    model_mem[addr] = data;
  endtask

  // Walk the program from address 0 the way a run is defined to behave.
  task automatic model_run(input int halt_at, output logic [4:0] exp_pc,
                           output logic [5:0] exp_cnt);
    int p = 0;
    int c = 0;
    for (int e = 1; e <= 40; e++) begin
      if (e == halt_at) break;
      if (model_mem[p][14:11] == 4'hF) break;
      exp_q.push_back(model_mem[p]);
      c++;
      if (p == 31) begin
        p = 0;
        break;
      end
      p++;
    end
    exp_pc  = 5'(p);
    exp_cnt = 6'(c);
  endtask

  task automatic check_idle(input string tag);
    checkOutput({tag, "_pc"},      32'(bus.pc),        32'd0);
    checkOutput({tag, "_pgm_mem"}, 32'(bus.pgm_mem),   32'd0);
    checkOutput({tag, "_cnt"},     32'(bus.issue_cnt), 32'd0);
    checkOutput({tag, "_busy"},    32'(bus.busy),      32'd0);
    checkOutput({tag, "_done"},    32'(bus.done),      32'd0);
  endtask

  task automatic run_program(input string tag, input int halt_at, input int wr_at,
                             input logic [4:0] wr_addr, input logic [14:0] wr_data,
                             input bit poke_start);
    logic [4:0] exp_pc;
    logic [5:0] exp_cnt;
    bit         finished = 1'b0;
    model_run(halt_at, exp_pc, exp_cnt);
    applyStimulus(1'b0, 5'd0, 15'd0, 1'b1, 1'b0);
    checkOutput({tag, "_start_busy"}, 32'(bus.busy),      32'd1);
    checkOutput({tag, "_start_done"}, 32'(bus.done),      32'd0);
    checkOutput({tag, "_start_pc"},   32'(bus.pc),        32'd0);
    checkOutput({tag, "_start_cnt"},  32'(bus.issue_cnt), 32'd0);
    for (int e = 1; e <= 64; e++) begin
      applyStimulus(e == wr_at, wr_addr, wr_data,
                    poke_start && ($urandom_range(0, 3) == 0), e == halt_at);
      if (bus.done) begin
        finished = 1'b1;
        break;
      end
    end
    checkOutput({tag, "_run_timeout"}, 32'(finished), 32'd1);
    applyStimulus(1'b0, 5'd0, 15'd0, 1'b0, 1'b0);
    checkOutput({tag, "_done"},    32'(bus.done),      32'd1);
    checkOutput({tag, "_busy"},    32'(bus.busy),      32'd0);
    checkOutput({tag, "_pc"},      32'(bus.pc),        32'(exp_pc));
    checkOutput({tag, "_cnt"},     32'(bus.issue_cnt), 32'(exp_cnt));
    checkOutput({tag, "_pgm_mem"}, 32'(bus.pgm_mem),   32'd0);
    checkOutput({tag, "_pending"}, 32'(exp_q.size()),  32'd0);
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [14:0] w;
    rst_fu = 1'b1;
    applyStimulus(1'b0, 5'd0, 15'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'd0, 15'd0, 1'b0, 1'b0);
    rst_fu = 1'b0;
    checking_on = 1'b1;
    check_idle("reset");

    // Three-word program ending in a halt word.
    write_word(5'd0, 15'h6108);
    write_word(5'd1, 15'h0A00);
    write_word(5'd2, 15'h7800);
    run_program("halt_word", 0, 0, 5'd0, 15'd0, 1'b0);
    checkOutput("halt_word_pc_const",  32'(bus.pc),        32'd2);
    checkOutput("halt_word_cnt_const", 32'(bus.issue_cnt), 32'd2);

    // Full store with no halt: wraps at the last address.
    for (int a = 0; a < 32; a++) write_word(5'(a), 15'h0800);
    run_program("full_store", 0, 0, 5'd0, 15'd0, 1'b0);
    checkOutput("full_store_cnt_const", 32'(bus.issue_cnt), 32'd32);

    run_program("halt_req", 3, 0, 5'd0, 15'd0, 1'b0);

    // Write attempted during RUN must not reach the store.
    write_word(5'd5, 15'h7800);
    run_program("wr_in_run", 0, 1, 5'd1, 15'h5555, 1'b0);
    run_program("wr_in_run_again", 0, 0, 5'd0, 15'd0, 1'b0);

    // start together with prog_wr in IDLE: write only.
    rst_fu = 1'b1;
    applyStimulus(1'b0, 5'd0, 15'd0, 1'b0, 1'b0);
    rst_fu = 1'b0;
    applyStimulus(1'b1, 5'd0, 15'h2345, 1'b1, 1'b0);
    model_mem[0] = 15'h2345;
    check_idle("start_with_wr");
    write_word(5'd1, 15'h7800);
    run_program("start_with_wr_run", 0, 0, 5'd0, 15'd0, 1'b0);

    // Reset in the middle of a run, with a write that reset must block.
    write_word(5'd1, 15'h0800);
    write_word(5'd5, 15'h0800);
    write_word(5'd10, 15'h7800);
    for (int a = 0; a < 5; a++) exp_q.push_back(model_mem[a]);
    applyStimulus(1'b0, 5'd0, 15'd0, 1'b1, 1'b0);
    for (int e = 0; e < 5; e++) applyStimulus(1'b0, 5'd0, 15'd0, 1'b0, 1'b0);
    checkOutput("mid_run_pc", 32'(bus.pc), 32'd5);
    rst_fu = 1'b1;
    applyStimulus(1'b1, 5'd3, 15'h7800, 1'b0, 1'b0);
    rst_fu = 1'b0;
    check_idle("mid_run_reset");
    checkOutput("mid_run_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    run_program("restart", 0, 0, 5'd0, 15'd0, 1'b0);

    // Randomized programs, halts, stray writes and start pulses.
    for (int it = 0; it < 20; it++) begin
      for (int a = 0; a < 32; a++) begin
        w = 15'($urandom);
        if ($urandom_range(0, 9) == 0) w[14:11] = 4'hF;
        else if (w[14:11] == 4'hF) w[14:11] = 4'h0;
        write_word(5'(a), w);
      end
      run_program("random",
                  ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 35)) : 0,
                  int'($urandom_range(0, 20)), 5'($urandom), 15'($urandom), 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        rst_fu = 1'b1;
        applyStimulus(1'b0, 5'd0, 15'd0, 1'b0, 1'b0);
        rst_fu = 1'b0;
        check_idle("random_reset");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
